// File: rtl/fpga_reset_seq_pkg.sv
// Shared types and sizing helpers for the FPGA reset/start sequencer.
package fpga_reset_seq_pkg;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        HOLD  = 3'd1,
        GAP_S = 3'd2,
        DLY   = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int cnt_width(input int hold, input int sgap, input int dgap);
        int m;
        m = hold;
        if (sgap > m) m = sgap;
        if (dgap > m) m = dgap;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

    function automatic int vec_width(input int resets, input int starts, input int delays);
        return resets + starts + delays;
    endfunction

endpackage

// File: rtl/fpga_reset_sync.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts on the second clock edge.
module fpga_reset_sync (
    input  logic clk_i,
    input  logic rst_i,
    output logic rst_sync_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], 1'b0};
    end

    assign rst_sync_o = sync_q[1];

endmodule

// File: rtl/fpga_reset_seq.sv
// Cycle-counted reset/start/delay release sequencer for emulated netlists.
// Define FPGA_RESET_SEQ_SOFT_EN to add the soft_req restart input.
module fpga_reset_seq
    import fpga_reset_seq_pkg::*;
#(
    parameter int RESETS      = 1,
    parameter int STARTS      = 0,
    parameter int DELAYS      = 0,
    parameter int HOLD_CYCLES = 16,
    parameter int START_GAP   = 8,
    parameter int DELAY_GAP   = 4
) (
    input  logic CLK,
    input  logic RESET,
`ifdef FPGA_RESET_SEQ_SOFT_EN
    input  logic soft_req,
`endif
    output logic [vec_width(RESETS, STARTS, DELAYS)-1:0] reset_n,
    output logic busy,
    output logic done
);

    localparam int W  = vec_width(RESETS, STARTS, DELAYS);
    localparam int CW = cnt_width(HOLD_CYCLES, START_GAP, DELAY_GAP);
    localparam int KW = (DELAYS > 1) ? $clog2(DELAYS) : 1;

    logic          rst_sync;
    logic          soft_w;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  rn_q, rn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rel_r, rel_s, fin;

`ifdef FPGA_RESET_SEQ_SOFT_EN
    assign soft_w = soft_req;
`else
    assign soft_w = 1'b0;
`endif

    fpga_reset_sync u_sync (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .rst_sync_o (rst_sync)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= SYNC;
            cnt_q   <= '0;
            k_q     <= '0;
            rn_q    <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            rn_q    <= rn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // The edge that leaves SYNC is the first hold cycle, hence the HOLD_CYCLES-2 threshold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        rn_d    = rn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        rel_r   = 1'b0;
        rel_s   = 1'b0;
        fin     = 1'b0;

        case (state_q)
            SYNC: begin
                if (!rst_sync) begin
                    if (HOLD_CYCLES <= 1) begin
                        rel_r = 1'b1;
                    end else begin
                        state_d = HOLD;
                        cnt_d   = '0;
                    end
                end
            end
            HOLD: begin
                if (int'(cnt_q) >= HOLD_CYCLES - 2) rel_r = 1'b1;
                else                                cnt_d = cnt_q + 1'b1;
            end
            GAP_S: begin
                if (int'(cnt_q) >= START_GAP - 1) rel_s = 1'b1;
                else                              cnt_d = cnt_q + 1'b1;
            end
            DLY: begin
                if (int'(cnt_q) >= DELAY_GAP - 1) begin
                    for (int i = 0; i < W; i++)
                        if (i == RESETS + STARTS + int'(k_q)) rn_d[i] = 1'b1;
                    cnt_d = '0;
                    if (int'(k_q) >= DELAYS - 1) fin = 1'b1;
                    else                         k_d = k_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: ;
            default: state_d = SYNC;
        endcase

        if (rel_r) begin
            for (int i = 0; i < RESETS; i++) rn_d[i] = 1'b1;
            cnt_d = '0;
            k_d   = '0;
            if (STARTS > 0)      state_d = GAP_S;
            else if (DELAYS > 0) state_d = DLY;
            else                 fin = 1'b1;
        end

        if (rel_s) begin
            for (int i = 0; i < W; i++)
                if (i >= RESETS && i < RESETS + STARTS) rn_d[i] = 1'b1;
            cnt_d = '0;
            k_d   = '0;
            if (DELAYS > 0) state_d = DLY;
            else            fin = 1'b1;
        end

        if (fin) begin
            state_d = DONE;
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        // Restart wins over any release scheduled for the same edge.
        if (soft_w && state_q != SYNC) begin
            state_d = HOLD;
            cnt_d   = '0;
            k_d     = '0;
            rn_d    = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end
    end

    assign reset_n = rn_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fpga_reset_seq.sv
// Directed bench: default config plus a staggered RESETS/STARTS/DELAYS config.
module tb_fpga_reset_seq;

    logic       CLK = 1'b0;
    logic       rst_a = 1'b1;
    logic       rst_b = 1'b1;
    logic       soft_b = 1'b0;
    logic [0:0] rn_a;
    logic       busy_a, done_a;
    logic [5:0] rn_b;
    logic       busy_b, done_b;
    int         checks = 0;
    int         failures = 0;

    always #5 CLK = ~CLK;

    fpga_reset_seq dut_a (
        .CLK     (CLK),
        .RESET   (rst_a),
`ifdef FPGA_RESET_SEQ_SOFT_EN
        .soft_req(1'b0),
`endif
        .reset_n (rn_a),
        .busy    (busy_a),
        .done    (done_a)
    );

    fpga_reset_seq #(
        .RESETS(2), .STARTS(1), .DELAYS(3),
        .HOLD_CYCLES(4), .START_GAP(2), .DELAY_GAP(3)
    ) dut_b (
        .CLK     (CLK),
        .RESET   (rst_b),
`ifdef FPGA_RESET_SEQ_SOFT_EN
        .soft_req(soft_b),
`endif
        .reset_n (rn_b),
        .busy    (busy_b),
        .done    (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // {done, busy, reset_n[0]} after edge En for the default config
    function automatic logic [2:0] exp_a(input int n);
        return (n >= 17) ? 3'b101 : 3'b010;
    endfunction

    // {done, busy, reset_n[5:0]} after edge En for the staggered config
    function automatic logic [7:0] exp_b(input int n);
        logic [7:0] v;
        v = 8'b0100_0000;
        if (n >= 5)  v[1:0] = 2'b11;
        if (n >= 7)  v[2]   = 1'b1;
        if (n >= 10) v[3]   = 1'b1;
        if (n >= 13) v[4]   = 1'b1;
        if (n >= 16) v[7:5] = 3'b101;
        return v;
    endfunction

    task automatic run_a(input string nm);
        for (int n = 0; n <= 20; n++) begin
            @(posedge CLK); #1;
            chk($sformatf("%s_E%0d", nm, n), {done_a, busy_a, rn_a}, exp_a(n));
        end
    endtask

    task automatic run_b(input string nm, input int last);
        for (int n = 0; n <= last; n++) begin
            @(posedge CLK); #1;
            chk($sformatf("%s_E%0d", nm, n), {done_b, busy_b, rn_b}, exp_b(n));
        end
    endtask

    initial begin
        repeat (5) @(posedge CLK);
        #1;
        chk("a_reset", {done_a, busy_a, rn_a}, 3'b010);
        chk("b_reset", {done_b, busy_b, rn_b}, 8'h40);

        @(negedge CLK) rst_a = 1'b0;
        run_a("a_seq");

        // sub-cycle pulse: asynchronous clear, then a complete sequence
        @(negedge CLK);
        #2 rst_a = 1'b1;
        #1 chk("a_pulse_async", {done_a, busy_a, rn_a}, 3'b010);
        #1 rst_a = 1'b0;
        run_a("a_pulse_seq");

        @(negedge CLK) rst_b = 1'b0;
        run_b("b_seq", 18);

        // reassert after E8, observed before the next edge
        @(negedge CLK) rst_b = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK) rst_b = 1'b0;
        run_b("b_pre", 8);
        #2 rst_b = 1'b1;
        #1 chk("b_mid_async", {done_b, busy_b, rn_b}, 8'h40);
        @(negedge CLK) rst_b = 1'b0;
        run_b("b_rerun", 18);

`ifdef FPGA_RESET_SEQ_SOFT_EN
        // soft restart from DONE, held for 3 edges
        @(negedge CLK) soft_b = 1'b1;
        for (int m = 0; m < 3; m++) begin
            @(posedge CLK); #1;
            chk($sformatf("soft_hold%0d", m), {done_b, busy_b, rn_b}, 8'h40);
            chk($sformatf("soft_cnt%0d", m), dut_b.cnt_q, 0);
        end
        @(negedge CLK) soft_b = 1'b0;
        for (int m = 1; m <= 3; m++) begin
            @(posedge CLK); #1;
            chk($sformatf("soft_rel%0d", m), {done_b, busy_b, rn_b}, (m == 3) ? 8'h43 : 8'h40);
        end

        // soft_req on the edge that would release delay bit 0 (E10)
        @(negedge CLK) rst_b = 1'b1;
        @(negedge CLK) rst_b = 1'b0;
        run_b("b_pre_soft", 9);
        @(negedge CLK) soft_b = 1'b1;
        @(posedge CLK); #1;
        chk("soft_edge_vec", {done_b, busy_b, rn_b}, 8'h40);
        chk("soft_edge_state", dut_b.state_q, fpga_reset_seq_pkg::HOLD);
        chk("soft_edge_cnt", dut_b.cnt_q, 0);
        @(negedge CLK) soft_b = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpga_reset_seq.md
# fpga_reset_seq

Synthesizable reset/start sequencer for FPGA builds of csp2verilog designs. It consumes the board clock and a raw asynchronous reset. It produces the same `reset_n` vector layout the simulation reset generator drives into the emulated netlist: RESETS group, then STARTS group, then DELAYS group. Deassertion is counted in clock cycles and synchronous to CLK, so no `#` delays are needed on hardware.

## Interface
- RESETS, 1, number of primary reset_n bits, index [RESETS-1:0]
- STARTS, 0, number of start bits, index [RESETS+STARTS-1:RESETS]
- DELAYS, 0, number of staggered delay bits, index above STARTS
- HOLD_CYCLES, 16, cycles all bits stay low after synchronized reset release (>=1)
- START_GAP, 8, cycles between RESETS release and STARTS release (>=1)
- DELAY_GAP, 4, cycles between consecutive releases in the delay phase (>=1)

- CLK  in  1  clock
- RESET  in  1  asynchronous, active-high reset
- soft_req  in  1  synchronous restart request (only with FPGA_RESET_SEQ_SOFT_EN)
- reset_n  out  RESETS+STARTS+DELAYS  active-low reset/start vector to the emulated design
- busy  out  1  high while sequence is in progress
- done  out  1  high once every bit is released

## Operation
- Reset values: reset_n all 0, busy 1, done 0, FSM in SYNC, counter 0.
- RESET release passes through a 2-flop synchronizer. Both flops are asynchronously set by RESET. The FSM leaves SYNC when the synchronized reset is low.
- States: SYNC -> HOLD -> GAP_S -> DLY -> DONE.
- HOLD: count HOLD_CYCLES, then set reset_n[RESETS-1:0]=1.
- GAP_S: skipped if STARTS==0. Count START_GAP, then set all STARTS bits to 1 together.
- DLY: skipped if DELAYS==0. Release delay bit k (k=0..DELAYS-1, ascending index) after each DELAY_GAP count. The counter reloads after each release.
- DONE: terminal. busy=0, done=1, reset_n all 1.
- Released bits never return to 0 except on RESET or soft_req.
- One counter, width = clog2(max(HOLD_CYCLES,START_GAP,DELAY_GAP)+1). It clears on every state entry and never wraps.

## Timing
- Edge E0 is the first CLK rising edge with RESET low. The synchronizer output falls at E1, and HOLD counting starts at E2.
- RESETS bits rise at E(1+HOLD_CYCLES).
- STARTS bits rise START_GAP edges later.
- Delay bit k rises (k+1)*DELAY_GAP edges after the previous phase release.
- done rises, and busy falls, on the same edge as the final release.
- RESET asserted at any time forces all outputs to reset values immediately (asynchronous), mid-sequence included.
- RESET pulse shorter than one cycle: still produces a full sequence.

## Configuration
- FPGA_RESET_SEQ_SOFT_EN defined: soft_req port exists.
  - soft_req high on an edge in any state except SYNC: all reset_n go to 0, done=0, busy=1, state=HOLD, counter cleared.
  - soft_req has priority over counter progress and same-edge releases.
  - While soft_req is held high, the block stays in HOLD with the counter at 0.
- Undefined: no soft_req port. Only RESET restarts the sequence.

## Structure
- fpga_reset_seq_pkg holds:
  - the state enum (SYNC, HOLD, GAP_S, DLY, DONE)
  - a constant-function for counter width
  - the width helper RESETS+STARTS+DELAYS
- Sub-module fpga_reset_sync: the 2-flop async-assert/sync-deassert synchronizer, reusable by other FPGA runtime blocks.

## Test plan
- Defaults (RESETS=1, STARTS=0, DELAYS=0), RESET high 5 cycles then low -> reset_n[0] rises at E17; done rises at E17; busy 1 until then.
- RESETS=2, STARTS=1, DELAYS=3, HOLD=4, START_GAP=2, DELAY_GAP=3 -> [1:0] at E5, [2] at E7, [3] at E10, [4] at E13, [5] at E16 with done.
- RESET reasserted at E8 of the previous config -> reset_n=0 asynchronously (before next edge). After release, the full sequence repeats with the same offsets.
- SOFT_EN build, soft_req high for 3 cycles while in DONE -> reset_n=0 on the next edge; after soft_req falls, RESETS release HOLD_CYCLES later.
- SOFT_EN build, soft_req on the same edge a delay bit would release -> bit stays 0, state HOLD, counter 0.
